expr_eval: RTL

- Downstream consumer of the ASCII expression-recognizer stream.
- Takes the same character stream (single-digit operands, '+' and '*') and evaluates the expression as it arrives, with '*' binding tighter than '+'.
- Presents the running result whenever the stream so far forms a complete valid expression.
- Flags malformed input with a sticky error until cleared.

---
 rtl/expr_eval_pkg.sv | 17 +
 rtl/expr_eval_classify.sv | 20 ++
 rtl/expr_eval.sv | 138 +++++++++++++
 3 files changed

// File: rtl/expr_eval_pkg.sv
// Shared definitions for the ASCII expression stream blocks: evaluator state
// encodings and the character constants used by the classifier.
package expr_eval_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_NUM  = 2'd1;
    localparam state_t ST_OP   = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_ADD = 8'h2B;
    localparam logic [7:0] ASCII_MUL = 8'h2A;

endpackage

// File: rtl/expr_eval_classify.sv
// Combinational ASCII character classifier: digit / '+' / '*' / other.
module ascii_classify
    import expr_eval_pkg::*;
(
    input  logic [7:0] in_i,
    output logic       is_dig_o,
    output logic       is_add_o,
    output logic       is_mul_o,
    output logic [3:0] digit_o
);

    // Decode the character class; '0'..'9' are 0x30..0x39 so the low nibble is the value.
    always_comb begin
        is_dig_o = (in_i >= ASCII_0) && (in_i <= ASCII_9);
        is_add_o = (in_i == ASCII_ADD);
        is_mul_o = (in_i == ASCII_MUL);
        digit_o  = is_dig_o ? in_i[3:0] : 4'd0;
    end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit '+'/'*' expressions with '*' binding
// tighter than '+'. sum_q holds the completed additive terms, prod_q the term
// currently being built; the running result is sum + prod, taken modulo 2^W.
module expr_eval
    import expr_eval_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic         out,
    output logic [W-1:0] value,
    output logic         err
);

    logic         is_dig;
    logic         is_add;
    logic         is_mul;
    logic [3:0]   digit;
    logic [W-1:0] d_ext;

    state_t       state_q, state_d;
    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] prod_q, prod_d;
    logic         mul_pend_q, mul_pend_d;
    logic         out_q, out_d;
    logic [W-1:0] value_q, value_d;
    logic         err_q, err_d;

    // Wrapping arithmetic: results are truncated to W bits, never saturated.
    function automatic logic [W-1:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return a + b;
    endfunction

    function automatic logic [W-1:0] mul_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return a * b;
    endfunction

    ascii_classify u_classify (
        .in_i     (in),
        .is_dig_o (is_dig),
        .is_add_o (is_add),
        .is_mul_o (is_mul),
        .digit_o  (digit)
    );

    assign d_ext = {{(W-4){1'b0}}, digit};

    // Next state, accumulator update and registered output values.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        prod_d     = prod_q;
        mul_pend_d = mul_pend_q;
        out_d      = out_q;
        value_d    = value_q;
        err_d      = err_q;

        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_dig) begin
                        state_d = ST_NUM;
                        prod_d  = d_ext;
                        sum_d   = '0;
                    end else if (is_add || is_mul) begin
                        state_d = ST_ERR;
                    end
                end
                ST_NUM: begin
                    if (is_dig) begin
                        // Operands are single digits; two in a row is malformed.
                        state_d = ST_ERR;
                    end else if (is_add) begin
                        state_d    = ST_OP;
                        sum_d      = add_w(sum_q, prod_q);
                        mul_pend_d = 1'b0;
                    end else if (is_mul) begin
                        state_d    = ST_OP;
                        mul_pend_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        sum_d   = '0;
                        prod_d  = '0;
                    end
                end
                ST_OP: begin
                    if (is_dig) begin
                        state_d = ST_NUM;
                        prod_d  = mul_pend_q ? mul_w(prod_q, d_ext) : d_ext;
                    end else if (is_add || is_mul) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_IDLE;
                        sum_d   = '0;
                        prod_d  = '0;
                    end
                end
                default: begin
                    // Error is sticky; only the reset leaves it.
                    state_d = ST_ERR;
                end
            endcase

            out_d   = (state_d == ST_NUM);
            err_d   = (state_d == ST_ERR);
            value_d = (state_d == ST_NUM) ? add_w(sum_d, prod_d) : '0;
        end
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            sum_q      <= '0;
            prod_q     <= '0;
            mul_pend_q <= 1'b0;
            out_q      <= 1'b0;
            value_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            prod_q     <= prod_d;
            mul_pend_q <= mul_pend_d;
            out_q      <= out_d;
            value_q    <= value_d;
            err_q      <= err_d;
        end
    end

    assign out   = out_q;
    assign value = value_q;
    assign err   = err_q;

endmodule
